// File: rtl/cnt_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_ctrl_pkg : shared state type and mode constants for cnt_ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam logic c_MODE_WRAP = 1'b0;
    localparam logic c_MODE_SAT  = 1'b1;

endpackage : cnt_ctrl_pkg
`default_nettype wire

// File: rtl/cnt_ctrl_arith.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_ctrl_arith : next-count datapath with wrap/saturate boundary   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cnt_ctrl_arith
    import cnt_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] step,
    input  logic             up_dn,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt,
    output logic             boundary,
    output logic             bnd_ovf,
    output logic             bnd_udf
);

    localparam logic [WIDTH:0] c_max_ext = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] c_mod     = c_max_ext + (WIDTH+1)'(1);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_gap;

    // One spare bit keeps cnt + step exact even when MAX_VAL is all ones.
    assign w_sum = {1'b0, cnt} + {1'b0, step};
    assign w_gap = {1'b0, step} - {1'b0, cnt};

    always_comb begin
        nxt      = cnt;
        boundary = 1'b0;
        bnd_ovf  = 1'b0;
        bnd_udf  = 1'b0;
        if (up_dn) begin
            if (w_sum > c_max_ext) begin
                boundary = 1'b1;
                bnd_ovf  = 1'b1;
                nxt      = (mode == c_MODE_SAT) ? c_max_ext[WIDTH-1:0]
                                                : WIDTH'(w_sum - c_mod);
            end else begin
                nxt = w_sum[WIDTH-1:0];
            end
        end else begin
            if (cnt < step) begin
                boundary = 1'b1;
                bnd_udf  = 1'b1;
                // cnt + (MAX_VAL+1) - step, rearranged so no term exceeds WIDTH+1 bits.
                nxt      = (mode == c_MODE_SAT) ? '0 : WIDTH'(c_mod - w_gap);
            end else begin
                nxt = cnt - step;
            end
        end
    end

endmodule : cnt_ctrl_arith
`default_nettype wire

// File: rtl/cnt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cnt_ctrl : up/down counter with modulus, wrap/saturate, one-shot   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned RST_VAL  = 0,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             udf,
    output logic             busy,
    output logic             done
);

    generate
        if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH - 1)) begin : g_bad_max_val
            $error("cnt_ctrl: MAX_VAL out of range 1..2**WIDTH-1");
        end
        if (RST_VAL > MAX_VAL) begin : g_bad_rst_val
            $error("cnt_ctrl: RST_VAL exceeds MAX_VAL");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_rst  = WIDTH'(RST_VAL);
    localparam logic             c_mode = SAT_MODE ? c_MODE_SAT : c_MODE_WRAP;

    cnt_state_t       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;
    logic             r_udf;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_nxt;
    logic             w_bnd;
    logic             w_bnd_ovf;
    logic             w_bnd_udf;
    logic             w_count_en;

    // Clamping keeps cnt inside 0..MAX_VAL, which the datapath relies on.
    assign w_step     = (step > c_max)     ? c_max : step;
    assign w_load_val = (load_val > c_max) ? c_max : load_val;
    assign w_count_en = (r_state == RUN) && en && (w_step != '0);

    cnt_ctrl_arith #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_arith (
        .cnt      (r_cnt),
        .step     (w_step),
        .up_dn    (up_dn),
        .mode     (c_mode),
        .nxt      (w_nxt),
        .boundary (w_bnd),
        .bnd_ovf  (w_bnd_ovf),
        .bnd_udf  (w_bnd_udf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= c_rst;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (clr_flags) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end
            if (load) begin
                r_cnt <= w_load_val;
            end else if (stop) begin
                r_state <= IDLE;
            end else if (start && (r_state != RUN)) begin
                r_state <= RUN;
                r_cnt   <= c_rst;
            end else if (w_count_en) begin
                r_cnt <= w_nxt;
                // Later assignments override a coincident clr_flags.
                if (w_bnd) begin
                    r_tc <= 1'b1;
                    if (w_bnd_ovf) r_ovf <= 1'b1;
                    if (w_bnd_udf) r_udf <= 1'b1;
                    if (oneshot)   r_state <= DONE;
                end
            end
        end
    end

    assign cnt  = r_cnt;
    assign tc   = r_tc;
    assign ovf  = r_ovf;
    assign udf  = r_udf;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule : cnt_ctrl
`default_nettype wire

// File: tb/tb_cnt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cnt_ctrl : four cnt_ctrl configurations against a reference     |
// | model, directed scenarios then random stimulus. Rev 1.0            |
// +--------------------------------------------------------------------+
module tb_cnt_ctrl;

    localparam int N = 4;
    // inst0: decade wrap, inst1: 8-bit saturate, inst2: mod-4 wrap, inst3: saturate 0..200 reset to 5
    localparam logic [N-1:0][7:0] C_MAX = {8'd200, 8'd3, 8'd255, 8'd9};
    localparam logic [N-1:0][7:0] C_RST = {8'd5,   8'd0, 8'd0,   8'd0};
    localparam logic [N-1:0]      C_SAT = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, oneshot, up_dn, en, load, clr_flags;
    logic [7:0] step, load_val;

    logic [7:0] cnt_w  [N];
    logic       tc_w   [N];
    logic       ovf_w  [N];
    logic       udf_w  [N];
    logic       busy_w [N];
    logic       done_w [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        cnt_ctrl #(
            .WIDTH    (8),
            .MAX_VAL  (int'(C_MAX[g])),
            .RST_VAL  (int'(C_RST[g])),
            .SAT_MODE (C_SAT[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .stop      (stop),
            .oneshot   (oneshot),
            .up_dn     (up_dn),
            .step      (step),
            .en        (en),
            .load      (load),
            .load_val  (load_val),
            .clr_flags (clr_flags),
            .cnt       (cnt_w[g]),
            .tc        (tc_w[g]),
            .ovf       (ovf_w[g]),
            .udf       (udf_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g])
        );
    end

    // Reference model: 0 = idle, 1 = run, 2 = done
    int m_state [N];
    int m_cnt   [N];
    bit m_tc    [N];
    bit m_ovf   [N];
    bit m_udf   [N];

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "init";

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int mx, s, v;
            bit sat;
            mx  = int'(C_MAX[i]);
            sat = C_SAT[i];
            if (!rst_n) begin
                m_state[i] = 0;
                m_cnt[i]   = int'(C_RST[i]);
                m_tc[i]    = 0;
                m_ovf[i]   = 0;
                m_udf[i]   = 0;
            end else begin
                m_tc[i] = 0;
                if (clr_flags) begin
                    m_ovf[i] = 0;
                    m_udf[i] = 0;
                end
                if (load) begin
                    m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
                end else if (stop) begin
                    m_state[i] = 0;
                end else if (start && m_state[i] != 1) begin
                    m_state[i] = 1;
                    m_cnt[i]   = int'(C_RST[i]);
                end else if (m_state[i] == 1 && en && step != 0) begin
                    s = (int'(step) > mx) ? mx : int'(step);
                    v = up_dn ? m_cnt[i] + s : m_cnt[i] - s;
                    if (v > mx || v < 0) begin
                        m_tc[i] = 1;
                        if (v > mx) begin
                            m_ovf[i] = 1;
                            m_cnt[i] = sat ? mx : v - (mx + 1);
                        end else begin
                            m_udf[i] = 1;
                            m_cnt[i] = sat ? 0 : v + (mx + 1);
                        end
                        if (oneshot) m_state[i] = 2;
                    end else begin
                        m_cnt[i] = v;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("%s/inst%0d", phase, i),
                     {3'b0, cnt_w[i], tc_w[i], ovf_w[i], udf_w[i], busy_w[i], done_w[i]},
                     {3'b0, 8'(m_cnt[i]), m_tc[i], m_ovf[i], m_udf[i],
                      m_state[i] == 1, m_state[i] == 2});
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; up_dn = 1'b1;
        en = 1'b0; load = 1'b0; clr_flags = 1'b0; step = 8'd1; load_val = 8'd0;
        phase = "reset";
        tick(2);
        check_eq("reset_state", {3'b0, cnt_w[3], tc_w[3], ovf_w[3], udf_w[3], busy_w[3], done_w[3]},
                 16'(5 << 5));
        rst_n = 1'b1;

        phase = "t1_reset_mid";
        start = 1'b1; tick();
        start = 1'b0; en = 1'b1; tick(5);
        check_eq("t1_cnt5", 16'(cnt_w[0]), 16'd5);
        rst_n = 1'b0; tick();
        check_eq("t1_after_rst", {3'b0, cnt_w[0], tc_w[0], ovf_w[0], udf_w[0], busy_w[0], done_w[0]}, 16'd0);
        rst_n = 1'b1;

        phase = "t2_decade";
        start = 1'b1; tick();
        start = 1'b0; tick(10);
        check_eq("t2_wrap_tc_ovf", 16'({cnt_w[0], tc_w[0], ovf_w[0]}), 16'd3);
        tick();
        check_eq("t2_ovf_sticky", 16'({cnt_w[0], tc_w[0], ovf_w[0]}), 16'd5);
        clr_flags = 1'b1; tick();
        check_eq("t2_ovf_clr", 16'(ovf_w[0]), 16'd0);
        clr_flags = 1'b0;

        phase = "t3_wrap_down";
        en = 1'b0; load = 1'b1; load_val = 8'd2; tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b0; step = 8'd3; tick();
        check_eq("t3_2m3_is_9", 16'({cnt_w[0], tc_w[0], udf_w[0]}), 16'd39);
        tick();
        check_eq("t3_next_6", 16'({cnt_w[0], tc_w[0]}), 16'd12);

        phase = "t4_saturate";
        stop = 1'b1; tick();
        stop = 1'b0; start = 1'b1; tick();
        start = 1'b0; en = 1'b0; load = 1'b1; load_val = 8'd254; tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1; step = 8'd1; tick();
        check_eq("t4_reach_255", 16'({cnt_w[1], tc_w[1]}), 16'd510);
        tick();
        check_eq("t4_rail_tc", 16'({cnt_w[1], tc_w[1], ovf_w[1]}), 16'd1023);
        en = 1'b0; load = 1'b1; load_val = 8'd2; clr_flags = 1'b1; tick();
        load = 1'b0; clr_flags = 1'b0; en = 1'b1; up_dn = 1'b0; step = 8'd4; tick();
        check_eq("t4_sat_zero", 16'({cnt_w[1], udf_w[1]}), 16'd1);

        phase = "t5_oneshot";
        stop = 1'b1; tick();
        stop = 1'b0; oneshot = 1'b1; up_dn = 1'b1; step = 8'd1; start = 1'b1; tick();
        start = 1'b0; tick(4);
        check_eq("t5_done", 16'({cnt_w[2], busy_w[2], done_w[2]}), 16'd1);
        tick();
        check_eq("t5_held", 16'({cnt_w[2], busy_w[2], done_w[2]}), 16'd1);
        start = 1'b1; tick();
        check_eq("t5_restart", 16'({cnt_w[2], busy_w[2], done_w[2]}), 16'd2);
        start = 1'b0; oneshot = 1'b0;

        phase = "t6_priority";
        en = 1'b0; load = 1'b1; load_val = 8'd200; tick();
        check_eq("t6_clamp", 16'(cnt_w[0]), 16'd9);
        load = 1'b0; start = 1'b1; stop = 1'b1; tick();
        check_eq("t6_stop_wins", 16'({busy_w[0], done_w[0]}), 16'd0);
        stop = 1'b0; tick();
        start = 1'b0; load = 1'b1; load_val = 8'd9; clr_flags = 1'b1; tick();
        load = 1'b0; en = 1'b1; tick();
        check_eq("t6_set_beats_clr", 16'({tc_w[0], ovf_w[0]}), 16'd3);
        clr_flags = 1'b0; tick();
        step = 8'd0; tick();
        check_eq("t6_step0_hold", 16'({cnt_w[0], tc_w[0]}), 16'd2);

        phase = "random";
        for (int k = 0; k < 3000; k++) begin
            rst_n     = ($urandom_range(63) != 0);
            load      = ($urandom_range(15) == 0);
            stop      = ($urandom_range(31) == 0);
            start     = ($urandom_range(7) == 0);
            clr_flags = ($urandom_range(15) == 0);
            if ($urandom_range(63) == 0) oneshot = ~oneshot;
            up_dn     = 1'($urandom_range(1));
            en        = ($urandom_range(3) != 0);
            step      = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(4));
            load_val  = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cnt_ctrl
`default_nettype wire

// File: doc/cnt_ctrl.md
Name: cnt_ctrl

Overview:
- Parametrised up/down counter controller; next generation of the team's fixed 8-bit counter.
- Adds:
  - runtime direction, step and parallel load;
  - programmable modulus;
  - wrap or saturate mode;
  - one-shot/free-run FSM;
  - terminal-count pulse and sticky overflow/underflow flags.
- Used as a timebase/event counter in SVA-checked designs.

Parameters:
- WIDTH, 8: counter width in bits.
- MAX_VAL, 2**WIDTH-1: terminal value; count range is 0..MAX_VAL. Legal range 1 <= MAX_VAL <= 2**WIDTH-1, checked at elaboration.
- RST_VAL, 0: value cnt takes on reset and on start from IDLE. Must be <= MAX_VAL.
- SAT_MODE, 0: 0 = wrap modulo MAX_VAL+1; 1 = saturate at MAX_VAL / 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  begin counting (IDLE/DONE -> RUN)
- stop  in  1  halt counting (-> IDLE); cnt is held
- oneshot  in  1  1: stop in DONE on first boundary event; 0: free-run
- up_dn  in  1  1 = count up, 0 = count down
- step  in  WIDTH  increment/decrement per enabled cycle; 0 = hold; values > MAX_VAL are clamped to MAX_VAL
- en  in  1  count enable while in RUN
- load  in  1  parallel load of cnt
- load_val  in  WIDTH  load data; values > MAX_VAL are clamped to MAX_VAL
- clr_flags  in  1  clear ovf/udf
- cnt  out  WIDTH  current count
- tc  out  1  one-cycle pulse on boundary event
- ovf  out  1  sticky: up-count crossed/reached beyond MAX_VAL
- udf  out  1  sticky: down-count went below 0
- busy  out  1  state == RUN
- done  out  1  state == DONE

Behaviour:
- All state is updated on posedge clk.
- Reset (rst_n=0 at an edge):
  - state = IDLE, cnt = RST_VAL, tc = ovf = udf = 0.
  - Reset overrides every other input, including mid-count.
- FSM states IDLE, RUN, DONE:
  - IDLE --start--> RUN, with cnt = RST_VAL.
  - RUN --stop--> IDLE.
  - RUN --boundary event & oneshot--> DONE.
  - DONE --start--> RUN, with cnt = RST_VAL.
  - DONE --stop--> IDLE.
- Input priority: rst_n > load > stop > start > count.
  - load in any state sets cnt = clamp(load_val). The state is unchanged and no tc is produced.
  - stop and start together: stop wins.
- Counting happens only when state == RUN, en = 1 and step != 0. Intermediate arithmetic is WIDTH+1 bits.
- Up count:
  - If cnt + s > MAX_VAL, this is a boundary event. Wrap gives cnt + s - (MAX_VAL+1); saturate gives MAX_VAL. ovf is set.
  - Otherwise cnt + s.
- Down count:
  - If cnt < s, this is a boundary event. Wrap gives cnt + (MAX_VAL+1) - s; saturate gives 0. udf is set.
  - Otherwise cnt - s.
- Saturate mode at a rail (cnt == MAX_VAL counting up, or 0 counting down): every enabled cycle is a boundary event. tc pulses each such cycle.
- tc is registered. It is high exactly in the cycle after the edge that performed the boundary update.
- Flag clearing and setting:
  - clr_flags clears ovf/udf at the edge.
  - A boundary event in the same cycle as clr_flags wins, so the flag is set.
- Direction or step changes take effect on the next enabled edge; no pipeline.
- busy and done are decoded from the registered state, with no extra latency.
- Outputs are registered or state-decoded only; there is no combinational input-to-output path.

Decomposition:
- cnt_ctrl_pkg holds:
  - typedef enum logic [1:0] cnt_state_t {IDLE, RUN, DONE};
  - localparam SAT/WRAP mode constants.
- Sub-module cnt_ctrl_arith (combinational):
  - inputs: cnt, step, up_dn, mode;
  - outputs: next value, boundary flag, direction of boundary (ovf/udf).
- cnt_ctrl holds the FSM, registers, clamps and priority logic.

Test Plan:
1. Reset mid-count: WIDTH=8, MAX_VAL=9, start, count to cnt=5, then rst_n=0 for 1 edge -> cnt=0, IDLE, tc/ovf/udf=0 at the next edge.
2. Wrap up, decade: MAX_VAL=9, SAT_MODE=0, step=1, up, free-run from 0 -> sequence 0..9,0. tc is high only the cycle after 9->0. ovf=1 stays high until clr_flags.
3. Wrap down with step 3: MAX_VAL=9, cnt loaded with 2, down, step=3 -> cnt=9 (2+10-3), udf=1, tc pulse. Next edge -> 6.
4. Saturate: SAT_MODE=1, MAX_VAL=255, load 254, up, step=1 -> 255 (no tc), then 255 held with tc high on each enabled cycle and ovf=1. Switch to down, step=4, with load 2 -> 0 and udf=1.
5. One-shot: MAX_VAL=3, oneshot=1, step=1, start -> 0,1,2,3,0 then DONE. done=1, busy=0, cnt=0 held with en=1. start -> RUN from RST_VAL.
6. Priority and clamp:
   - load=1, load_val=200 with MAX_VAL=9 -> cnt=9.
   - start+stop together -> IDLE.
   - clr_flags coincident with a boundary event -> flag remains 1.
   - step=0 with en=1 -> cnt held, no tc.
